dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning data-memory size in 32-bit words.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive CPU grants after which a waiting loader wins.
REQ-003 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have ports: start  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: cpu_req in 1 CPU access request; cpu_we in 1 CPU write (sw); cpu_addr in 32 byte address (DA); cpu_wdata in 32 store data.
REQ-006 SHALL have ports: cpu_rdata out 32 load data; cpu_stall out 1 CPU must hold PC and inputs.
REQ-007 SHALL have ports: ld_req in 1 loader/debug request; ld_we in 1; ld_addr in 32; ld_wdata in 32.
REQ-008 SHALL have ports: ld_gnt out 1 loader request accepted; ld_rdata out 32; ld_rvalid out 1 loader read data valid.
REQ-009 SHALL have ports: mem_en out 1; mem_wea out 4; mem_addr out 32 word address; mem_din out 32; mem_dout in 32 (BRAM, 1-cycle read latency).
REQ-010 SHALL have ports: addr_err out 1 one-cycle pulse on an out-of-range access.

Function
REQ-011 SHALL implement FSM states IDLE, CPU_RD, LD_RD; writes complete in IDLE without a state change.
REQ-012 In IDLE with a request present, SHALL grant exactly one requester per cycle; CPU wins unless ld_req=1 and starve_cnt==STARVE_MAX.
REQ-013 starve_cnt SHALL increment (saturating at STARVE_MAX) on each CPU grant while ld_req=1, and SHALL clear on any loader grant or when ld_req=0.
REQ-014 A granted write SHALL drive mem_en=1, mem_wea=4'b1111, mem_addr=addr[31:2], mem_din=wdata in the grant cycle, and SHALL complete in that cycle.
REQ-015 A granted read SHALL drive mem_en=1, mem_wea=0, mem_addr=addr[31:2], then move to CPU_RD or LD_RD.
REQ-016 In CPU_RD, SHALL present cpu_rdata=mem_dout, deassert cpu_stall, return to IDLE, and issue no new access that cycle.
REQ-017 In LD_RD, SHALL present ld_rdata=mem_dout with ld_rvalid=1 for exactly one cycle, then return to IDLE.
REQ-018 cpu_stall SHALL equal cpu_req AND NOT (CPU write granted this cycle OR state==CPU_RD); CPU load latency is 2 cycles, store latency is 1 cycle when uncontended.
REQ-019 ld_gnt SHALL pulse high for one cycle in the loader grant cycle only.
REQ-020 An access with addr[31:2] >= DEPTH SHALL suppress the write (mem_wea=0, mem_en=0), return data 0, pulse addr_err, and otherwise follow normal timing.
REQ-021 Address bits [1:0] SHALL be ignored (word-aligned only).
REQ-022 When the FSM is not in IDLE, new requests SHALL wait; requesters hold their inputs until they are granted or unstalled.
REQ-023 When idle, outputs SHALL be mem_en=0, mem_wea=0, ld_gnt=0, ld_rvalid=0, and cpu_rdata/ld_rdata hold their last value.

Reset
REQ-024 start=1 at a clock edge SHALL force state=IDLE, starve_cnt=0, cpu_rdata=0, ld_rdata=0, ld_rvalid=0, ld_gnt=0, addr_err=0, mem_en=0, mem_wea=0.
REQ-025 start=1 during CPU_RD or LD_RD SHALL abandon the read without asserting ld_rvalid; cpu_stall SHALL be 0 while start=1.

Structure
REQ-026 State encoding and the word-address width function SHALL live in a shared package (kgp_pkg), alongside the opcode constants used by the CPU.
REQ-027 The starvation counter plus grant decision SHALL be one sub-module, rr_starve_ctr; the remainder stays flat.
REQ-028 The block SHALL sit between kgp_risc (DA, write_data, wea, doutd) and the data BRAM, with cpu_stall gating the PC update.

Verification
REQ-029 CPU sw to addr 0x10, data 0xDEADBEEF, no loader -> same cycle: mem_addr=4, mem_wea=1111, cpu_stall=0.
REQ-030 CPU lw from 0x10 -> cycle 0: cpu_stall=1, mem_en=1; cycle 1: cpu_rdata=0xDEADBEEF, cpu_stall=0.
REQ-031 Simultaneous cpu_req and ld_req held, CPU issuing back-to-back writes, STARVE_MAX=4 -> 4 CPU grants, then ld_gnt on the 5th, then starve_cnt=0.
REQ-032 Loader read of 0x20 after loader write 0x12345678 -> ld_rvalid=1 with ld_rdata=0x12345678 exactly one cycle after ld_gnt.
REQ-033 CPU write to addr 4*DEPTH -> addr_err pulse, mem_wea=0, memory unchanged on readback.
REQ-034 start asserted in CPU_RD -> next cycle state IDLE, cpu_rdata=0, ld_rvalid=0, cpu_stall=0.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared types for the kgp core: arbiter FSM states, word-address helpers
// and the RV32 opcode constants decoded by kgp_risc.
package kgp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        LD_RD  = 2'd2
    } arb_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Bits needed to index a memory of depth_words 32-bit words.
    function automatic int unsigned waddr_width(input int unsigned depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

    // Byte address to word address; the two byte-offset bits are dropped.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbitration bus: CPU port, loader/debug port and BRAM port.
// slave = arbiter view, master = requesters plus BRAM view.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic [31:0] ld_rdata;
    logic        ld_rvalid;

    logic        mem_en;
    logic [3:0]  mem_wea;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic        addr_err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rdata, ld_rvalid,
        output mem_en, mem_wea, mem_addr, mem_din,
        input  mem_dout,
        output addr_err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rdata, ld_rvalid,
        input  mem_en, mem_wea, mem_addr, mem_din,
        output mem_dout,
        input  addr_err
    );
endinterface

// File: rtl/rr_starve_ctr.sv
// CPU-priority grant with loader anti-starvation; grants are combinational
// in the idle cycle, the loader wins after STARVE_MAX consecutive CPU grants.
module rr_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic start,
    input  logic idle,
    input  logic cpu_req,
    input  logic ld_req,
    output logic cpu_gnt,
    output logic ld_gnt
);
    localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    assign ld_gnt  = idle && ld_req && (!cpu_req || starve_cnt == CNT_MAX);
    assign cpu_gnt = idle && cpu_req && !ld_gnt;

    // Counts only CPU wins that the loader actually lost.
    always_ff @(posedge clk) begin
        if (start || !ld_req || ld_gnt) begin
            starve_cnt <= '0;
        end else if (cpu_gnt && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates kgp_risc and the loader onto one BRAM: writes finish in the grant
// cycle, reads return one cycle later; losers wait (cpu_stall / no ld_gnt).
module dmem_arbiter
    import kgp_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          start,
    dmem_arbiter_if.slave bus
);
    arb_state_t  state;
    logic        rd_err_q;
    logic [31:0] cpu_rdata_q;
    logic [31:0] ld_rdata_q;

    logic        can_grant;
    logic        cpu_gnt;
    logic        ld_gnt_i;
    logic        granted;
    logic        sel_we;
    logic        oor;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] sel_waddr;
    logic [31:0] rd_data;

    assign can_grant = (state == IDLE) && !start;

    rr_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .start   (start),
        .idle    (can_grant),
        .cpu_req (bus.cpu_req),
        .ld_req  (bus.ld_req),
        .cpu_gnt (cpu_gnt),
        .ld_gnt  (ld_gnt_i)
    );

    always_comb begin
        granted   = cpu_gnt | ld_gnt_i;
        sel_we    = ld_gnt_i ? bus.ld_we    : bus.cpu_we;
        sel_addr  = ld_gnt_i ? bus.ld_addr  : bus.cpu_addr;
        sel_wdata = ld_gnt_i ? bus.ld_wdata : bus.cpu_wdata;
        sel_waddr = word_addr(sel_addr);
        oor       = sel_waddr >= DEPTH;
        rd_data   = rd_err_q ? 32'h0 : bus.mem_dout;
    end

    // Out-of-range accesses never touch the BRAM but keep normal timing.
    assign bus.mem_en    = granted && !oor;
    assign bus.mem_wea   = (granted && sel_we && !oor) ? 4'hF : 4'h0;
    assign bus.mem_addr  = sel_waddr;
    assign bus.mem_din   = sel_wdata;
    assign bus.addr_err  = granted && oor;
    assign bus.ld_gnt    = ld_gnt_i;
    assign bus.ld_rvalid = (state == LD_RD) && !start;
    assign bus.cpu_stall = bus.cpu_req && !start &&
                           !((cpu_gnt && bus.cpu_we) || state == CPU_RD);
    assign bus.cpu_rdata = (state == CPU_RD) ? rd_data : cpu_rdata_q;
    assign bus.ld_rdata  = (state == LD_RD)  ? rd_data : ld_rdata_q;

    always_ff @(posedge clk) begin
        if (start) begin
            state       <= IDLE;
            rd_err_q    <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (granted && !sel_we) begin
                        state    <= cpu_gnt ? CPU_RD : LD_RD;
                        rd_err_q <= oor;
                    end
                end
                CPU_RD: begin
                    cpu_rdata_q <= rd_data;
                    state       <= IDLE;
                end
                LD_RD: begin
                    ld_rdata_q <= rd_data;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: BRAM model, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;
    localparam int unsigned TB_DEPTH = 64;
    localparam int          AW       = 6;
    localparam int          SM       = 4;

    logic clk = 1'b0;
    logic start;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(
        .DEPTH      (TB_DEPTH),
        .STARVE_MAX (SM)
    ) dut (
        .clk   (clk),
        .start (start),
        .bus   (bus)
    );

    // BRAM with one-cycle registered read.
    logic [31:0] bram [TB_DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_addr < 32'(TB_DEPTH)) begin
            if (bus.mem_wea != 4'h0) bram[bus.mem_addr[AW-1:0]] <= bus.mem_din;
            else                     bus.mem_dout <= bram[bus.mem_addr[AW-1:0]];
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: expected memory, who is waiting for read data and what it is.
    logic [31:0] ref_mem [TB_DEPTH];
    int          starve   = 0;
    int          busy     = 0;   // 0 none, 1 CPU read in flight, 2 loader read in flight
    logic [31:0] pend     = '0;
    logic [31:0] held_cpu = '0;
    logic [31:0] held_ld  = '0;
    logic        e_gc, e_gl, e_stall, e_oor, e_we;
    logic [31:0] e_addr, e_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        e_gc = 1'b0;
        e_gl = 1'b0;
        if (!start && busy == 0) begin
            if (bus.ld_req && (!bus.cpu_req || starve == SM)) e_gl = 1'b1;
            else if (bus.cpu_req)                             e_gc = 1'b1;
        end
        e_we    = e_gl ? bus.ld_we    : bus.cpu_we;
        e_addr  = e_gl ? bus.ld_addr  : bus.cpu_addr;
        e_wdata = e_gl ? bus.ld_wdata : bus.cpu_wdata;
        e_oor   = (e_addr / 4) >= TB_DEPTH;
        e_stall = bus.cpu_req && !start && !(e_gc && bus.cpu_we) && busy != 1;
        chk("m_cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        chk("m_mem_en",    32'(bus.mem_en),    32'((e_gc || e_gl) && !e_oor));
        chk("m_mem_wea",   32'(bus.mem_wea),   ((e_gc || e_gl) && e_we && !e_oor) ? 32'hF : 32'h0);
        chk("m_ld_gnt",    32'(bus.ld_gnt),    32'(e_gl));
        chk("m_addr_err",  32'(bus.addr_err),  32'((e_gc || e_gl) && e_oor));
        chk("m_ld_rvalid", 32'(bus.ld_rvalid), 32'(!start && busy == 2));
        if ((e_gc || e_gl) && !e_oor)         chk("m_mem_addr", bus.mem_addr, e_addr >> 2);
        if ((e_gc || e_gl) && e_we && !e_oor) chk("m_mem_din",  bus.mem_din,  e_wdata);
        if (!start) begin
            chk("m_cpu_rdata", bus.cpu_rdata, (busy == 1) ? pend : held_cpu);
            chk("m_ld_rdata",  bus.ld_rdata,  (busy == 2) ? pend : held_ld);
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        if (start) begin
            starve   = 0;
            busy     = 0;
            held_cpu = '0;
            held_ld  = '0;
        end else begin
            if (busy == 1)      held_cpu = pend;
            else if (busy == 2) held_ld  = pend;
            busy = 0;
            if (e_gc || e_gl) begin
                if (e_we) begin
                    if (!e_oor) ref_mem[e_addr[AW+1:2]] = e_wdata;
                end else begin
                    pend = e_oor ? 32'h0 : ref_mem[e_addr[AW+1:2]];
                    busy = e_gc ? 1 : 2;
                end
            end
            if (!bus.ld_req || e_gl)      starve = 0;
            else if (e_gc && starve < SM) starve++;
        end
        cyc++;
        #1;
    endtask

    task automatic tick();
        cyc_begin();
        cyc_end();
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
        tick();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
        tick();
        cyc_begin();
        d = bus.cpu_rdata;
        cyc_end();
        bus.cpu_req = 1'b0;
    endtask

    logic [31:0] rd;
    int          first_ld, second_ld;
    logic        g_l, g_c, cpu_done, ld_done;

    initial begin
        for (int i = 0; i < int'(TB_DEPTH); i++) begin
            bram[i]    = '0;
            ref_mem[i] = '0;
        end
        bus.mem_dout = '0;
        idle_inputs();
        start = 1'b1;
        bus.cpu_req = 1'b1;

        // Reset behaviour
        cyc_begin();
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
        chk("rst_mem_en",    32'(bus.mem_en),    32'h0);
        cyc_end();
        tick();
        start = 1'b0;
        idle_inputs();
        cyc_begin();
        chk("rst_cpu_rdata", bus.cpu_rdata,       32'h0);
        chk("rst_ld_rdata",  bus.ld_rdata,        32'h0);
        chk("rst_ld_rvalid", 32'(bus.ld_rvalid),  32'h0);
        chk("rst_addr_err",  32'(bus.addr_err),   32'h0);
        chk("rst_mem_wea",   32'(bus.mem_wea),    32'h0);
        cyc_end();

        // Uncontended store completes in its grant cycle
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
        cyc_begin();
        chk("sw_mem_addr",  bus.mem_addr,         32'h4);
        chk("sw_mem_wea",   32'(bus.mem_wea),     32'hF);
        chk("sw_mem_din",   bus.mem_din,          32'hDEADBEEF);
        chk("sw_cpu_stall", 32'(bus.cpu_stall),   32'h0);
        cyc_end();

        // Load takes two cycles
        bus.cpu_we = 1'b0;
        cyc_begin();
        chk("lw_c0_stall",  32'(bus.cpu_stall), 32'h1);
        chk("lw_c0_mem_en", 32'(bus.mem_en),    32'h1);
        cyc_end();
        cyc_begin();
        chk("lw_c1_rdata",  bus.cpu_rdata,      32'hDEADBEEF);
        chk("lw_c1_stall",  32'(bus.cpu_stall), 32'h0);
        cyc_end();
        bus.cpu_req = 1'b0;
        cyc_begin();
        chk("lw_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);
        cyc_end();

        // Byte-offset bits are ignored
        cpu_read(32'h13, rd);
        chk("lw_unaligned", rd, 32'hDEADBEEF);

        // Starvation: CPU streams writes while the loader waits
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h100;
        bus.ld_req  = 1'b1; bus.ld_we  = 1'b1; bus.ld_addr  = 32'h20; bus.ld_wdata  = 32'h12345678;
        first_ld = -1;
        second_ld = -1;
        for (int k = 0; k < 12; k++) begin
            cyc_begin();
            g_l = bus.ld_gnt;
            g_c = bus.cpu_req && !bus.cpu_stall;
            cyc_end();
            if (g_l) begin
                if (first_ld < 0) begin
                    first_ld = k;
                    bus.ld_addr = 32'h24; bus.ld_wdata = 32'hA5A50001;
                end else if (second_ld < 0) begin
                    second_ld = k;
                    bus.ld_req = 1'b0;
                end
            end
            if (g_c) begin
                bus.cpu_addr  = bus.cpu_addr + 32'h4;
                bus.cpu_wdata = bus.cpu_wdata + 32'h1;
            end
        end
        chk("starve_first_ld_gnt",  32'(first_ld),  32'd4);
        chk("starve_second_ld_gnt", 32'(second_ld), 32'd9);
        idle_inputs();

        // Loader read returns data one cycle after its grant
        bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h20;
        cyc_begin();
        chk("ldrd_gnt", 32'(bus.ld_gnt), 32'h1);
        cyc_end();
        bus.ld_req = 1'b0;
        cyc_begin();
        chk("ldrd_rvalid", 32'(bus.ld_rvalid), 32'h1);
        chk("ldrd_rdata",  bus.ld_rdata,       32'h12345678);
        chk("ldrd_gnt_pulse", 32'(bus.ld_gnt), 32'h0);
        cyc_end();
        cyc_begin();
        chk("ldrd_rvalid_once", 32'(bus.ld_rvalid), 32'h0);
        cyc_end();

        // Out-of-range write is dropped and flagged
        cpu_write(32'h0, 32'h11110000);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'(4 * TB_DEPTH); bus.cpu_wdata = 32'hCAFEF00D;
        cyc_begin();
        chk("oor_addr_err", 32'(bus.addr_err),  32'h1);
        chk("oor_mem_wea",  32'(bus.mem_wea),   32'h0);
        chk("oor_mem_en",   32'(bus.mem_en),    32'h0);
        chk("oor_stall",    32'(bus.cpu_stall), 32'h0);
        cyc_end();
        bus.cpu_req = 1'b0;
        cyc_begin();
        chk("oor_err_pulse", 32'(bus.addr_err), 32'h0);
        cyc_end();
        cpu_read(32'h0, rd);
        chk("oor_mem_unchanged", rd, 32'h11110000);
        cpu_read(32'(4 * TB_DEPTH), rd);
        chk("oor_read_zero", rd, 32'h0);

        // Reset during CPU_RD abandons the load
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
        tick();
        start = 1'b1;
        cyc_begin();
        chk("rst_rd_stall", 32'(bus.cpu_stall), 32'h0);
        cyc_end();
        start = 1'b0;
        bus.cpu_req = 1'b0;
        cyc_begin();
        chk("rst_rd_cpu_rdata", bus.cpu_rdata,       32'h0);
        chk("rst_rd_rvalid",    32'(bus.ld_rvalid),  32'h0);
        chk("rst_rd_stall2",    32'(bus.cpu_stall),  32'h0);
        cyc_end();

        // Reset during LD_RD suppresses ld_rvalid
        bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h20;
        tick();
        start = 1'b1;
        bus.ld_req = 1'b0;
        cyc_begin();
        chk("rst_ldrd_rvalid", 32'(bus.ld_rvalid), 32'h0);
        cyc_end();
        start = 1'b0;
        cyc_begin();
        chk("rst_ldrd_rdata", bus.ld_rdata, 32'h0);
        cyc_end();

        // Randomized traffic from both requesters against the model
        idle_inputs();
        for (int n = 0; n < 3000; n++) begin
            cyc_begin();
            cpu_done = bus.cpu_req && !e_stall;
            ld_done  = bus.ld_req && e_gl;
            cyc_end();
            start = ($urandom_range(0, 199) == 0);
            if (!bus.cpu_req || cpu_done) begin
                if ($urandom_range(0, 99) < 60) begin
                    bus.cpu_req   = 1'b1;
                    bus.cpu_we    = $urandom_range(0, 1) == 1;
                    bus.cpu_addr  = (32'($urandom_range(0, TB_DEPTH + 3)) << 2) | 32'($urandom_range(0, 3));
                    bus.cpu_wdata = $urandom;
                end else begin
                    bus.cpu_req = 1'b0;
                end
            end
            if (!bus.ld_req || ld_done) begin
                if ($urandom_range(0, 99) < 40) begin
                    bus.ld_req   = 1'b1;
                    bus.ld_we    = $urandom_range(0, 1) == 1;
                    bus.ld_addr  = (32'($urandom_range(0, TB_DEPTH + 3)) << 2) | 32'($urandom_range(0, 3));
                    bus.ld_wdata = $urandom;
                end else begin
                    bus.ld_req = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
